// File: rtl/parking_pkg.sv
// -----------------------------------------------------------------------------
// parking_pkg
// Shared widths, limits and the billing state encoding for the parking
// billing slice.
//   CAR_W    : width of a car index
//   TIME_W   : width of the free-running time counter and entry times
//   COST_W   : width of a cost value
//   NUM_CARS : number of valid car slots (indices 0..NUM_CARS-1)
//   COST_MAX : largest representable cost; products above it saturate
// -----------------------------------------------------------------------------
package parking_pkg;

    localparam int CAR_W    = 2;
    localparam int TIME_W   = 10;
    localparam int COST_W   = 10;
    localparam int NUM_CARS = 3;
    localparam int COST_MAX = 1023;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CALC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } bill_state_t;

    // A car index is usable only if it names one of the populated slots.
    function automatic logic car_valid(input logic [CAR_W-1:0] car);
        return (32'(car) < NUM_CARS);
    endfunction

endpackage

// File: rtl/cost_calc.sv
// -----------------------------------------------------------------------------
// cost_calc
// Combinational cost from a parked duration:
//   cost = min(duration * RATE, COST_MAX), optionally floored at MIN_CHARGE.
// Optional feature macro: BILLING_MIN_CHARGE_EN (enables the MIN_CHARGE floor).
// Ports:
//   duration : input  [TIME_W-1:0] parked duration in time units
//   cost     : output [COST_W-1:0] saturated (and optionally floored) cost
// -----------------------------------------------------------------------------
module cost_calc
    import parking_pkg::*;
#(
    parameter int RATE       = 2,
    parameter int MIN_CHARGE = 5
) (
    input  logic [TIME_W-1:0] duration,
    output logic [COST_W-1:0] cost
);

    // Product is wide enough that duration*RATE never overflows before the
    // saturation compare.
    localparam int PW = TIME_W + $clog2(RATE + 1);

`ifdef BILLING_MIN_CHARGE_EN
    localparam logic [COST_W-1:0] FLOOR_V = COST_W'(MIN_CHARGE);
`else
    // With the floor disabled it collapses to zero, so the max() below is a
    // pass-through and folds away.
    localparam logic [COST_W-1:0] FLOOR_V = COST_W'(MIN_CHARGE * 0);
`endif

    logic [PW-1:0]     product;
    logic [COST_W-1:0] sat;

    always_comb begin
        product = PW'(duration) * PW'(RATE);
        if (product > PW'(COST_MAX)) begin
            sat = COST_W'(COST_MAX);
        end else begin
            sat = product[COST_W-1:0];
        end
        cost = (sat > FLOOR_V) ? sat : FLOOR_V;
    end

endmodule

// File: rtl/billing_reader.sv
// -----------------------------------------------------------------------------
// billing_reader
// Bills a departing car: reads its entry time from the entry/cost store,
// computes the parked duration and cost, writes the cost back and reports it.
// Sequence (one cycle per non-IDLE state): IDLE -> READ -> CALC -> WRITE ->
// DONE -> IDLE. A request accepted at edge 0 gives the store write in cycle 3,
// done in cycle 4, and the next request can be accepted in cycle 5.
// Optional feature macro: BILLING_MIN_CHARGE_EN (minimum charge floor, see
// cost_calc).
//
// Handshake: exit_req is a single-cycle request sampled only in IDLE; while
// busy is high it is dropped (no queuing, no error). An out-of-range car index
// in IDLE is refused with a one-cycle error pulse and no store access.
//
// Ports:
//   clk            : input       clock, rising edge
//   reset          : input       asynchronous active-low reset
//   exit_req       : input       one-cycle billing request
//   exit_car       : input  [1:0] car index, sampled with exit_req
//   cur_time       : input  [9:0] free-running time, sampled with exit_req
//   mem_car_sel    : output [1:0] car index presented to the store
//   mem_entry_time : input  [9:0] combinational entry time for mem_car_sel
//   mem_write_cost : output      one-cycle cost write strobe
//   mem_cost       : output [9:0] cost data for the write strobe
//   busy           : output      high whenever not in IDLE
//   done           : output      one-cycle completion pulse
//   bill           : output [9:0] last completed cost
//   error          : output      one-cycle pulse on a refused request
// -----------------------------------------------------------------------------
module billing_reader
    import parking_pkg::*;
#(
    parameter int RATE       = 2,
    parameter int MIN_CHARGE = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exit_req,
    input  logic [CAR_W-1:0]  exit_car,
    input  logic [TIME_W-1:0] cur_time,
    output logic [CAR_W-1:0]  mem_car_sel,
    input  logic [TIME_W-1:0] mem_entry_time,
    output logic              mem_write_cost,
    output logic [COST_W-1:0] mem_cost,
    output logic              busy,
    output logic              done,
    output logic [COST_W-1:0] bill,
    output logic              error
);

    bill_state_t       state;
    logic [CAR_W-1:0]  car_q;
    logic [TIME_W-1:0] time_q;
    logic [TIME_W-1:0] duration_q;
    logic [COST_W-1:0] cost_q;
    logic [COST_W-1:0] cost_next;

    cost_calc #(
        .RATE       (RATE),
        .MIN_CHARGE (MIN_CHARGE)
    ) u_cost_calc (
        .duration (duration_q),
        .cost     (cost_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            car_q          <= '0;
            time_q         <= '0;
            duration_q     <= '0;
            cost_q         <= '0;
            mem_car_sel    <= '0;
            mem_write_cost <= 1'b0;
            mem_cost       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            bill           <= '0;
            error          <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them.
            mem_write_cost <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (exit_req) begin
                        if (car_valid(exit_car)) begin
                            car_q       <= exit_car;
                            time_q      <= cur_time;
                            // Select the car now so the entry time is
                            // readable throughout READ.
                            mem_car_sel <= exit_car;
                            busy        <= 1'b1;
                            state       <= S_READ;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end

                S_READ: begin
                    // Natural TIME_W-bit wrap gives the modulo duration when
                    // the counter rolled over while the car was parked.
                    duration_q <= time_q - mem_entry_time;
                    state      <= S_CALC;
                end

                S_CALC: begin
                    cost_q         <= cost_next;
                    mem_cost       <= cost_next;
                    mem_write_cost <= 1'b1;
                    mem_car_sel    <= car_q;
                    state          <= S_WRITE;
                end

                S_WRITE: begin
                    mem_cost    <= '0;
                    mem_car_sel <= '0;
                    done        <= 1'b1;
                    state       <= S_DONE;
                end

                S_DONE: begin
                    bill  <= cost_q;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    mem_car_sel <= '0;
                    mem_cost    <= '0;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_billing_reader.sv
// -----------------------------------------------------------------------------
// tb_billing_reader
// Directed bench for billing_reader with RATE=2. A small entry-time store
// model drives mem_entry_time; a write monitor checks every store write
// against an expected-cost queue.
// -----------------------------------------------------------------------------
module tb_billing_reader;

    logic       clk;
    logic       reset;
    logic       exit_req;
    logic [1:0] exit_car;
    logic [9:0] cur_time;
    logic [1:0] mem_car_sel;
    logic [9:0] mem_entry_time;
    logic       mem_write_cost;
    logic [9:0] mem_cost;
    logic       busy;
    logic       done;
    logic [9:0] bill;
    logic       error;

    int total;
    int bad;
    int wr_count;

    logic [9:0] entry_mem [0:3];
    logic [9:0] exp_q [$];

    billing_reader #(
        .RATE       (2),
        .MIN_CHARGE (5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .exit_req       (exit_req),
        .exit_car       (exit_car),
        .cur_time       (cur_time),
        .mem_car_sel    (mem_car_sel),
        .mem_entry_time (mem_entry_time),
        .mem_write_cost (mem_write_cost),
        .mem_cost       (mem_cost),
        .busy           (busy),
        .done           (done),
        .bill           (bill),
        .error          (error)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational store readback.
    assign mem_entry_time = entry_mem[mem_car_sel];

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Write monitor / scoreboard: sampled on the falling edge, away from
    // the register updates.
    always @(negedge clk) begin
        if (mem_write_cost === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", 32'(mem_cost), 32'hFFFF_FFFF);
            end else begin
                check_eq("sb_cost", 32'(mem_cost), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All bench activity happens 1 time unit after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
        check_eq({tag, "_error"}, 32'(error), 0);
        check_eq({tag, "_wr"}, 32'(mem_write_cost), 0);
        check_eq({tag, "_cost"}, 32'(mem_cost), 0);
        check_eq({tag, "_sel"}, 32'(mem_car_sel), 0);
    endtask

    // Issue a request (caller is positioned just after a falling edge) and
    // check every cycle through cycle 5. inject=1 raises a second request
    // during cycle 2 which must be ignored.
    task automatic bill_run(input string tag, input logic [1:0] car,
                            input logic [9:0] entry, input logic [9:0] now,
                            input logic [9:0] exp_cost, input bit inject);
        int wr0;
        entry_mem[car] = entry;
        exp_q.push_back(exp_cost);
        wr0 = wr_count;
        exit_req = 1'b1;
        exit_car = car;
        cur_time = now;
        @(posedge clk);
        #1;
        exit_req = 1'b0;
        cur_time = now + 10'd7;
        for (int c = 1; c <= 5; c++) begin
            step();
            check_eq({tag, "_busy"}, 32'(busy), (c <= 4) ? 1 : 0);
            check_eq({tag, "_wr"}, 32'(mem_write_cost), (c == 3) ? 1 : 0);
            check_eq({tag, "_done"}, 32'(done), (c == 4) ? 1 : 0);
            if (c == 1) check_eq({tag, "_sel_read"}, 32'(mem_car_sel), 32'(car));
            if (c == 3) begin
                check_eq({tag, "_sel_write"}, 32'(mem_car_sel), 32'(car));
                check_eq({tag, "_mem_cost"}, 32'(mem_cost), 32'(exp_cost));
            end
            if (c == 5) begin
                check_eq({tag, "_bill"}, 32'(bill), 32'(exp_cost));
                check_eq({tag, "_nwrites"}, 32'(wr_count - wr0), 1);
            end
            if (inject && c == 2) begin
                exit_req = 1'b1;
                exit_car = 2'd0;
            end
            if (c == 3) exit_req = 1'b0;
        end
        if (inject) begin
            step();
            check_eq({tag, "_no_queue_busy"}, 32'(busy), 0);
            check_eq({tag, "_no_queue_writes"}, 32'(wr_count - wr0), 1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int wr0;
        logic [9:0] bill_before;
        logic [9:0] floor_exp;
        total    = 0;
        bad      = 0;
        wr_count = 0;
        exit_req = 1'b0;
        exit_car = 2'd0;
        cur_time = 10'd0;
        for (int i = 0; i < 4; i++) entry_mem[i] = 10'd0;

        reset = 1'b0;
        #1;
        check_idle_outputs("reset");
        check_eq("reset_bill", 32'(bill), 0);
        repeat (2) @(posedge clk);
        step();
        reset = 1'b1;
        step();

        // Basic: duration 50 -> cost 100.
        bill_run("basic", 2'd1, 10'd100, 10'd150, 10'd100, 1'b0);
        // Back-to-back request accepted in cycle 5.
        bill_run("b2b", 2'd0, 10'd5, 10'd12, 10'd14, 1'b0);
        // Wrap-around: (20 - 1000) mod 1024 = 44 -> 88.
        bill_run("wrap", 2'd2, 10'd1000, 10'd20, 10'd88, 1'b0);
        // Saturation: 600*2 = 1200 -> 1023.
        bill_run("sat", 2'd0, 10'd0, 10'd600, 10'd1023, 1'b0);
        // Just below saturation: 511*2 = 1022.
        bill_run("sat_edge_lo", 2'd1, 10'd0, 10'd511, 10'd1022, 1'b0);
        // Exactly past: 512*2 = 1024 -> 1023.
        bill_run("sat_edge_hi", 2'd1, 10'd1, 10'd513, 10'd1023, 1'b0);
        // Zero duration: floored only when the feature is built in.
`ifdef BILLING_MIN_CHARGE_EN
        floor_exp = 10'd5;
`else
        floor_exp = 10'd0;
`endif
        bill_run("zero_dur", 2'd2, 10'd300, 10'd300, floor_exp, 1'b0);
        // Second request during cycle 2 must be ignored.
        bill_run("ignored", 2'd1, 10'd200, 10'd260, 10'd120, 1'b1);

        // Invalid car index: error pulse for one cycle, no write, stay idle.
        wr0 = wr_count;
        bill_before = bill;
        exit_req = 1'b1;
        exit_car = 2'd3;
        cur_time = 10'd400;
        @(posedge clk);
        #1;
        exit_req = 1'b0;
        step();
        check_eq("bad_car_error", 32'(error), 1);
        check_eq("bad_car_busy", 32'(busy), 0);
        step();
        check_eq("bad_car_error_off", 32'(error), 0);
        check_eq("bad_car_busy2", 32'(busy), 0);
        check_eq("bad_car_writes", 32'(wr_count - wr0), 0);
        check_eq("bad_car_bill", 32'(bill), 32'(bill_before));

        // Reset during cycle 2 aborts with no write.
        wr0 = wr_count;
        entry_mem[2] = 10'd10;
        exit_req = 1'b1;
        exit_car = 2'd2;
        cur_time = 10'd60;
        @(posedge clk);
        #1;
        exit_req = 1'b0;
        step();
        check_eq("abort_busy_pre", 32'(busy), 1);
        step();
        reset = 1'b0;
        #1;
        check_idle_outputs("abort");
        check_eq("abort_bill", 32'(bill), 0);
        repeat (3) step();
        reset = 1'b1;
        step();
        step();
        check_idle_outputs("abort_after");
        check_eq("abort_writes", 32'(wr_count - wr0), 0);

        // Recovery after reset.
        bill_run("recover", 2'd2, 10'd10, 10'd60, 10'd100, 1'b0);

        step();
        check_eq("sb_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/billing_reader.md
BILLING_READER -- requirements
Module: billing_reader

Interface
REQ-001 The block SHALL have parameter RATE, default 2, meaning cost units charged per time unit of parked duration.
REQ-002 The block SHALL have parameter MIN_CHARGE, default 5, meaning the minimum cost, used only when BILLING_MIN_CHARGE_EN is defined.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port exit_req  input  1  one-cycle request to bill a departing car.
REQ-006 The block SHALL have port exit_car  input  2  car index 0..2, sampled with exit_req.
REQ-007 The block SHALL have port cur_time  input  10  free-running time counter value.
REQ-008 The block SHALL have port mem_car_sel  output  2  car index presented to the entry/cost store.
REQ-009 The block SHALL have port mem_entry_time  input  10  combinational entry-time readback for mem_car_sel.
REQ-010 The block SHALL have port mem_write_cost  output  1  one-cycle cost write strobe to the store.
REQ-011 The block SHALL have port mem_cost  output  10  cost data written with mem_write_cost.
REQ-012 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 The block SHALL have port done  output  1  one-cycle pulse when billing completes.
REQ-014 The block SHALL have port bill  output  10  last completed cost, held until the next completion.
REQ-015 The block SHALL have port error  output  1  one-cycle pulse on a rejected request.

Function
REQ-016 The block SHALL implement states IDLE, READ, CALC, WRITE, DONE; each non-IDLE state SHALL last exactly one cycle.
REQ-017 In IDLE, exit_req=1 with exit_car<=2 SHALL latch exit_car and cur_time and move to READ at that edge (edge 0).
REQ-018 In IDLE, exit_req=1 with exit_car=3 SHALL stay in IDLE, pulse error for the following cycle, and perform no write.
REQ-019 exit_req while busy=1 SHALL be ignored, with no queuing and no error.
REQ-020 In READ, mem_car_sel SHALL equal the latched car; duration = (latched cur_time - mem_entry_time) mod 1024 SHALL be registered at edge 1.
REQ-021 In CALC, cost = min(duration*RATE, 1023) using a product of at least 10+clog2(RATE+1) bits SHALL be registered at edge 2.
REQ-022 In WRITE, mem_write_cost=1, mem_cost=cost, and mem_car_sel=latched car SHALL hold for exactly one cycle (cycle 3).
REQ-023 In DONE, done=1 SHALL hold for cycle 4, bill SHALL update at edge 4, and the FSM SHALL return to IDLE at edge 4.
REQ-024 Total latency SHALL be: request at edge 0, done high in cycle 4, next request accepted in cycle 5.
REQ-025 In IDLE, mem_car_sel SHALL be 0 and mem_write_cost SHALL be 0.

Reset
REQ-026 reset=0 SHALL asynchronously force state=IDLE and busy=0, done=0, error=0, mem_write_cost=0, mem_cost=0, mem_car_sel=0, bill=0, and all latched registers to 0.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no mem_write_cost pulse after reset assertion.

Configuration
REQ-028 With BILLING_MIN_CHARGE_EN defined, cost SHALL be max(min(duration*RATE,1023), MIN_CHARGE); without it, cost SHALL be min(duration*RATE,1023) and MIN_CHARGE SHALL be unused.

Structure
REQ-029 Package parking_pkg SHALL hold CAR_W=2, TIME_W=10, COST_W=10, NUM_CARS=3, COST_MAX=1023, and the billing state enum.
REQ-030 Sub-module cost_calc (combinational: duration, RATE -> saturated, optionally floored, cost) SHALL be instantiated by billing_reader.

Verification
REQ-031 The bench SHALL cover: RATE=2, car 1 entry 100, cur_time 150, exit_req -> mem_write_cost in cycle 3 with mem_car_sel=1 and mem_cost=100; done in cycle 4; bill=100.
REQ-032 The bench SHALL cover: entry 1000, cur_time 20 -> duration 44, mem_cost=88 (wrap-around).
REQ-033 The bench SHALL cover: entry 0, cur_time 600, RATE=2 -> mem_cost=1023 (saturation).
REQ-034 The bench SHALL cover: exit_car=3 -> error pulse for one cycle, busy stays 0, no write.
REQ-035 The bench SHALL cover: a second exit_req in cycle 2 -> ignored, with exactly one write; reset=0 in cycle 2 -> no write, all outputs 0.
REQ-036 The bench SHALL cover: with BILLING_MIN_CHARGE_EN defined, entry=cur_time=300 -> mem_cost=5; without it -> mem_cost=0.
